// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: FSM encoding, hit bit positions and
// playfield geometry used by the ball, renderer and wall drawing.
package breakout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    localparam int HIT_LEFT   = 0;
    localparam int HIT_TOP    = 1;
    localparam int HIT_RIGHT  = 2;
    localparam int HIT_PADDLE = 3;

    localparam int DEF_SCREEN_W  = 320;
    localparam int DEF_SCREEN_H  = 240;
    localparam int DEF_WALL_W    = 8;
    localparam int DEF_BALL_SIZE = 4;
    localparam int DEF_PADDLE_W  = 32;
    localparam int DEF_PADDLE_Y  = 224;
    localparam int DEF_X_W       = 9;
    localparam int DEF_Y_W       = 8;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis move with clamp-and-reflect against a low and a high bound.
// Comparisons run one bit wider than the coordinate so nothing wraps.
module ball_axis_step #(
    parameter int W  = 9,
    parameter int SW = 3,
    parameter int LO = 8,
    parameter int HI = 308
) (
    input  logic [W-1:0]  pos,
    input  logic [SW-1:0] step,
    input  logic          dec,
    output logic [W-1:0]  nxt,
    output logic          hit
);

    localparam logic [W:0] LO_E = (W+1)'(LO);
    localparam logic [W:0] HI_E = (W+1)'(HI);

    logic [W:0] pos_e;
    logic [W:0] step_e;
    logic [W:0] sum;
    logic [W:0] diff;

    assign pos_e  = {1'b0, pos};
    assign step_e = {{(W+1-SW){1'b0}}, step};
    assign sum    = pos_e + step_e;
    assign diff   = pos_e - step_e;

    always_comb begin
        nxt = pos;
        hit = 1'b0;
        if (dec) begin
            // pos - step < LO rewritten to avoid the subtraction underflow
            if (pos_e < LO_E + step_e) begin
                nxt = LO_E[W-1:0];
                hit = 1'b1;
            end else begin
                nxt = diff[W-1:0];
            end
        end else begin
            if (sum > HI_E) begin
                nxt = HI_E[W-1:0];
                hit = 1'b1;
            end else begin
                nxt = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/ball_physics.sv
// Breakout ball: per-frame motion, wall/paddle reflection, speed-up
// and the serve / play / miss sequence.
module ball_physics
    import breakout_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int WALL_W       = DEF_WALL_W,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_Y     = DEF_PADDLE_Y,
    parameter int X_W          = DEF_X_W,
    parameter int Y_W          = DEF_Y_W,
    parameter int MIN_STEP     = 1,
    parameter int MAX_STEP     = 4,
    parameter int SPEEDUP_HITS = 4,
    parameter int MISS_FRAMES  = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           launch,
    input  logic [X_W-1:0] paddle_x,
    output logic [X_W-1:0] ball_x,
    output logic [Y_W-1:0] ball_y,
    output logic           dir_left,
    output logic           dir_up,
    output logic [3:0]     hit,
    output logic           miss,
    output logic [1:0]     state
);

    localparam int SW = $clog2(MAX_STEP + 1);
    localparam int CW = $clog2(SPEEDUP_HITS + 1);
    localparam int TW = $clog2(MISS_FRAMES + 1);

    localparam logic [X_W-1:0] X_START  = X_W'(SCREEN_W/2 - BALL_SIZE/2);
    localparam logic [X_W-1:0] PARK_OFS = X_W'(PADDLE_W/2 - BALL_SIZE/2);
    localparam logic [Y_W-1:0] Y_PARK   = Y_W'(PADDLE_Y - BALL_SIZE);

    localparam logic [Y_W:0] BS_Y = (Y_W+1)'(BALL_SIZE);
    localparam logic [Y_W:0] PY_E = (Y_W+1)'(PADDLE_Y);
    localparam logic [Y_W:0] SH_E = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W:0] BS_X = (X_W+1)'(BALL_SIZE);
    localparam logic [X_W:0] HB_X = (X_W+1)'(BALL_SIZE/2);
    localparam logic [X_W:0] PW_X = (X_W+1)'(PADDLE_W);
    localparam logic [X_W:0] HP_X = (X_W+1)'(PADDLE_W/2);

    localparam logic [SW-1:0] STEP_MIN = SW'(MIN_STEP);
    localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPEEDUP_HITS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(MISS_FRAMES - 1);

    state_t         state_q;
    logic [SW-1:0]  step;
    logic [CW-1:0]  hit_cnt;
    logic [TW-1:0]  miss_tmr;

    logic [X_W-1:0] nx;
    logic           x_wall;
    logic [Y_W-1:0] ny_up;
    logic           y_top;

    logic [X_W:0]   nx_e;
    logic [X_W:0]   px_e;
    logic [Y_W:0]   by_e;
    logic [Y_W:0]   sy_e;
    logic [Y_W:0]   y_bot;
    logic [Y_W:0]   y_nbot;
    logic           pad_row;
    logic           pad_ovl;
    logic           pad_hit;
    logic           pad_left;
    logic           floor_hit;
    logic [Y_W-1:0] ny;
    logic           dl_nxt;
    logic           du_nxt;
    logic [3:0]     hit_nxt;

    ball_axis_step #(
        .W  (X_W),
        .SW (SW),
        .LO (WALL_W),
        .HI (SCREEN_W - WALL_W - BALL_SIZE)
    ) u_x_step (
        .pos  (ball_x),
        .step (step),
        .dec  (dir_left),
        .nxt  (nx),
        .hit  (x_wall)
    );

    ball_axis_step #(
        .W  (Y_W),
        .SW (SW),
        .LO (WALL_W),
        .HI (PADDLE_Y - BALL_SIZE)
    ) u_y_step (
        .pos  (ball_y),
        .step (step),
        .dec  (1'b1),
        .nxt  (ny_up),
        .hit  (y_top)
    );

    always_comb begin
        nx_e   = {1'b0, nx};
        px_e   = {1'b0, paddle_x};
        by_e   = {1'b0, ball_y};
        sy_e   = {{(Y_W+1-SW){1'b0}}, step};
        y_bot  = by_e + BS_Y;
        y_nbot = by_e + sy_e + BS_Y;

        pad_row   = (y_bot <= PY_E) && (y_nbot >= PY_E);
        pad_ovl   = (nx_e + BS_X > px_e) && (nx_e < px_e + PW_X);
        pad_hit   = !dir_up && pad_row && pad_ovl;
        pad_left  = (nx_e + HB_X) < (px_e + HP_X);
        floor_hit = !dir_up && !pad_hit && (y_nbot >= SH_E);

        if (dir_up) begin
            ny = ny_up;
        end else if (pad_hit) begin
            ny = Y_PARK;
        end else begin
            ny = ball_y + sy_e[Y_W-1:0];
        end

        // a paddle bounce steers x even when a side wall was also struck
        dl_nxt = pad_hit ? pad_left : (dir_left ^ x_wall);
        du_nxt = dir_up ? !y_top : pad_hit;

        hit_nxt             = '0;
        hit_nxt[HIT_LEFT]   = x_wall & dir_left;
        hit_nxt[HIT_RIGHT]  = x_wall & ~dir_left;
        hit_nxt[HIT_TOP]    = y_top & dir_up;
        hit_nxt[HIT_PADDLE] = pad_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ball_x   <= X_START;
            ball_y   <= Y_PARK;
            dir_left <= 1'b0;
            dir_up   <= 1'b1;
            hit      <= '0;
            miss     <= 1'b0;
            step     <= STEP_MIN;
            hit_cnt  <= '0;
            miss_tmr <= '0;
        end else begin
            hit  <= '0;
            miss <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        ball_x <= paddle_x + PARK_OFS;
                        ball_y <= Y_PARK;
                    end
                    if (launch) begin
                        state_q  <= ST_PLAY;
                        dir_left <= 1'b0;
                        dir_up   <= 1'b1;
                        step     <= STEP_MIN;
                        hit_cnt  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        if (floor_hit) begin
                            miss     <= 1'b1;
                            state_q  <= ST_MISS;
                            miss_tmr <= '0;
                        end else begin
                            ball_x   <= nx;
                            ball_y   <= ny;
                            dir_left <= dl_nxt;
                            dir_up   <= du_nxt;
                            hit      <= hit_nxt;
                            if (pad_hit) begin
                                if (hit_cnt == CNT_LAST) begin
                                    hit_cnt <= '0;
                                    if (step < STEP_MAX) begin
                                        step <= step + 1'b1;
                                    end
                                end else begin
                                    hit_cnt <= hit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_MISS: begin
                    if (frame_tick) begin
                        if (miss_tmr == TMR_LAST) begin
                            miss_tmr <= '0;
                            state_q  <= ST_IDLE;
                        end else begin
                            miss_tmr <= miss_tmr + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: serve, walls, paddle, speed-up,
// miss sequence and a corner bounce.
module tb_ball_physics;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       launch;
    logic [8:0] paddle_x;
    logic [8:0] ball_x;
    logic [7:0] ball_y;
    logic       dir_left;
    logic       dir_up;
    logic [3:0] hit;
    logic       miss;
    logic [1:0] state;

    int tests;
    int fails;

    ball_physics dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .launch     (launch),
        .paddle_x   (paddle_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .dir_left   (dir_left),
        .dir_up     (dir_up),
        .hit        (hit),
        .miss       (miss),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // called on a negedge; returns on the following negedge
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic serve();
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        paddle_x = 9'd144;
        repeat (2) @(negedge clk);
        tests++;
        if (state !== 2'd0 || ball_x !== 9'd158 || ball_y !== 8'd220 ||
            dir_left !== 1'b0 || dir_up !== 1'b1 || hit !== 4'd0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: st=%0d ball=(%0d,%0d) dl=%0d du=%0d hit=%b miss=%0d want 0 (158,220) 0 1 0000 0",
                     state, ball_x, ball_y, dir_left, dir_up, hit, miss);
        end
        reset = 1'b0;
        @(negedge clk);
        tick();
        tests++;
        if (state !== 2'd0 || ball_x !== 9'd158 || ball_y !== 8'd220 || hit !== 4'd0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL park_144: st=%0d ball=(%0d,%0d) hit=%b miss=%0d want 0 (158,220) 0000 0",
                     state, ball_x, ball_y, hit, miss);
        end
    endtask

    task automatic test_serve_right_wall();
        paddle_x = 9'd280;
        tick();
        tests++;
        if (ball_x !== 9'd294 || ball_y !== 8'd220) begin
            fails++;
            $display("FAIL park_280: ball=(%0d,%0d) want (294,220)", ball_x, ball_y);
        end
        serve();
        tests++;
        if (state !== 2'd1) begin
            fails++;
            $display("FAIL launch: state=%0d want 1", state);
        end
        repeat (14) tick();
        tests++;
        if (ball_x !== 9'd308 || ball_y !== 8'd206 || hit !== 4'd0) begin
            fails++;
            $display("FAIL tick14: ball=(%0d,%0d) hit=%b want (308,206) 0000", ball_x, ball_y, hit);
        end
        tick();
        tests++;
        if (ball_x !== 9'd308 || ball_y !== 8'd205 || hit !== 4'b0100 || dir_left !== 1'b1) begin
            fails++;
            $display("FAIL right_wall: ball=(%0d,%0d) hit=%b dl=%0d want (308,205) 0100 1",
                     ball_x, ball_y, hit, dir_left);
        end
        @(negedge clk);
        tests++;
        if (hit !== 4'd0) begin
            fails++;
            $display("FAIL right_pulse_width: hit=%b want 0000", hit);
        end
    endtask

    task automatic test_top_wall();
        int bad;
        bad = 0;
        repeat (197) begin
            tick();
            if (hit !== 4'd0) bad++;
        end
        tests++;
        if (bad != 0 || ball_x !== 9'd111 || ball_y !== 8'd8) begin
            fails++;
            $display("FAIL rise_to_top: stray_hits=%0d ball=(%0d,%0d) want 0 (111,8)", bad, ball_x, ball_y);
        end
        tick();
        tests++;
        if (hit !== 4'b0010 || ball_x !== 9'd110 || ball_y !== 8'd8 || dir_up !== 1'b0 || dir_left !== 1'b1) begin
            fails++;
            $display("FAIL top_wall: hit=%b ball=(%0d,%0d) du=%0d dl=%0d want 0010 (110,8) 0 1",
                     hit, ball_x, ball_y, dir_up, dir_left);
        end
        @(negedge clk);
        tests++;
        if (hit !== 4'd0) begin
            fails++;
            $display("FAIL top_pulse_width: hit=%b want 0000", hit);
        end
    endtask

    task automatic test_paddle_speedup();
        int hits;
        int guard;
        repeat (211) tick();
        tests++;
        if (ball_x !== 9'd116 || ball_y !== 8'd219) begin
            fails++;
            $display("FAIL descend: ball=(%0d,%0d) want (116,219)", ball_x, ball_y);
        end
        paddle_x = 9'd110;
        tick();
        tests++;
        if (hit !== 4'b1000 || ball_x !== 9'd117 || ball_y !== 8'd220 || dir_up !== 1'b1 || dir_left !== 1'b1) begin
            fails++;
            $display("FAIL paddle_hit: hit=%b ball=(%0d,%0d) du=%0d dl=%0d want 1000 (117,220) 1 1",
                     hit, ball_x, ball_y, dir_up, dir_left);
        end
        @(negedge clk);
        tests++;
        if (hit !== 4'd0) begin
            fails++;
            $display("FAIL paddle_pulse_width: hit=%b want 0000", hit);
        end
        hits = 1;
        guard = 0;
        while (hits < 4 && guard < 1500) begin
            paddle_x = (ball_x < 9'd22) ? 9'd8 : (ball_x > 9'd294) ? 9'd280 : ball_x - 9'd14;
            tick();
            guard++;
            if (hit[3]) hits++;
        end
        tests++;
        if (hits != 4 || ball_y !== 8'd220) begin
            fails++;
            $display("FAIL four_paddle_hits: hits=%0d ball_y=%0d want 4 220", hits, ball_y);
        end
        tick();
        tests++;
        if (ball_y !== 8'd218) begin
            fails++;
            $display("FAIL speedup_step: ball_y=%0d want 218", ball_y);
        end
    endtask

    task automatic test_reset_mid_play();
        frame_tick = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        tests++;
        if (state !== 2'd0 || ball_x !== 9'd158 || ball_y !== 8'd220 ||
            dir_left !== 1'b0 || dir_up !== 1'b1 || hit !== 4'd0 || miss !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_play: st=%0d ball=(%0d,%0d) dl=%0d du=%0d hit=%b miss=%0d want 0 (158,220) 0 1 0000 0",
                     state, ball_x, ball_y, dir_left, dir_up, hit, miss);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (hit !== 4'd0 || miss !== 1'b0 || state !== 2'd0) begin
            fails++;
            $display("FAIL after_reset: hit=%b miss=%0d st=%0d want 0000 0 0", hit, miss, state);
        end
    endtask

    task automatic test_miss();
        int bad;
        paddle_x = 9'd8;
        tick();
        tests++;
        if (ball_x !== 9'd22 || ball_y !== 8'd220) begin
            fails++;
            $display("FAIL park_8: ball=(%0d,%0d) want (22,220)", ball_x, ball_y);
        end
        serve();
        repeat (440) tick();
        tests++;
        if (ball_x !== 9'd155 || ball_y !== 8'd235 || state !== 2'd1 || miss !== 1'b0) begin
            fails++;
            $display("FAIL past_paddle: ball=(%0d,%0d) st=%0d miss=%0d want (155,235) 1 0",
                     ball_x, ball_y, state, miss);
        end
        tick();
        tests++;
        if (miss !== 1'b1 || state !== 2'd2 || ball_x !== 9'd155 || ball_y !== 8'd235) begin
            fails++;
            $display("FAIL miss_event: miss=%0d st=%0d ball=(%0d,%0d) want 1 2 (155,235)",
                     miss, state, ball_x, ball_y);
        end
        @(negedge clk);
        tests++;
        if (miss !== 1'b0) begin
            fails++;
            $display("FAIL miss_pulse_width: miss=%0d want 0", miss);
        end
        bad = 0;
        for (int i = 1; i < 60; i++) begin
            if (i == 20) serve();
            if (i == 30) launch = 1'b1;
            tick();
            launch = 1'b0;
            if (state !== 2'd2 || miss !== 1'b0 || ball_y !== 8'd235) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL miss_hold: %0d bad ticks, state=%0d want 0 bad, state 2", bad, state);
        end
        tick();
        tests++;
        if (state !== 2'd0) begin
            fails++;
            $display("FAIL miss_to_idle: state=%0d want 0", state);
        end
    endtask

    task automatic test_corner();
        paddle_x = 9'd206;
        tick();
        tests++;
        if (ball_x !== 9'd220 || ball_y !== 8'd220 || state !== 2'd0) begin
            fails++;
            $display("FAIL park_206: ball=(%0d,%0d) st=%0d want (220,220) 0", ball_x, ball_y, state);
        end
        serve();
        repeat (424) tick();
        tests++;
        if (ball_x !== 9'd42 || ball_y !== 8'd219) begin
            fails++;
            $display("FAIL corner_pass1: ball=(%0d,%0d) want (42,219)", ball_x, ball_y);
        end
        paddle_x = 9'd40;
        tick();
        tests++;
        if (hit !== 4'b1000 || ball_x !== 9'd43 || ball_y !== 8'd220 || dir_left !== 1'b1 || dir_up !== 1'b1) begin
            fails++;
            $display("FAIL corner_paddle1: hit=%b ball=(%0d,%0d) dl=%0d du=%0d want 1000 (43,220) 1 1",
                     hit, ball_x, ball_y, dir_left, dir_up);
        end
        repeat (424) tick();
        tests++;
        if (ball_x !== 9'd221 || ball_y !== 8'd219) begin
            fails++;
            $display("FAIL corner_pass2: ball=(%0d,%0d) want (221,219)", ball_x, ball_y);
        end
        paddle_x = 9'd216;
        tick();
        tests++;
        if (hit !== 4'b1000 || ball_x !== 9'd220 || ball_y !== 8'd220 || dir_left !== 1'b1) begin
            fails++;
            $display("FAIL corner_paddle2: hit=%b ball=(%0d,%0d) dl=%0d want 1000 (220,220) 1",
                     hit, ball_x, ball_y, dir_left);
        end
        repeat (212) tick();
        tests++;
        if (ball_x !== 9'd8 || ball_y !== 8'd8 || hit !== 4'd0) begin
            fails++;
            $display("FAIL corner_approach: ball=(%0d,%0d) hit=%b want (8,8) 0000", ball_x, ball_y, hit);
        end
        tick();
        tests++;
        if (hit !== 4'b0011 || ball_x !== 9'd8 || ball_y !== 8'd8 || dir_left !== 1'b0 || dir_up !== 1'b0) begin
            fails++;
            $display("FAIL corner_hit: hit=%b ball=(%0d,%0d) dl=%0d du=%0d want 0011 (8,8) 0 0",
                     hit, ball_x, ball_y, dir_left, dir_up);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        frame_tick = 1'b0;
        launch = 1'b0;
        paddle_x = 9'd144;
        @(negedge clk);
        test_reset();
        test_serve_right_wall();
        test_top_wall();
        test_paddle_speedup();
        test_reset_mid_play();
        test_miss();
        test_corner();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
